// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Holds the pipeline while
// iterating and presents {remainder, quotient} for the HI/LO write.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   remReg;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   divisor;
  logic               qSign, rSign;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               borrow;

  // Magnitude as an unsigned W-bit value; |-2^(W-1)| = 2^(W-1) still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v,
                                                 input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign aMag = magnitude(a, signed_div);
  assign bMag = magnitude(b, signed_div);

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // The low W bits of the difference are exact whenever there is no borrow.
  assign shifted = {remReg, quot[WIDTH-1]};
  assign borrow  = shifted < {1'b0, divisor};
  assign diff    = shifted[WIDTH-1:0] - divisor;

  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          stall     = 1'b1;
          stateNext = (b == '0) ? FINISH : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cancel)
          stateNext = IDLE;
        else if (count == CNT_W'(WIDTH - 1))
          stateNext = FINISH;
      end
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      count   <= '0;
      remReg  <= '0;
      quot    <= '0;
      divisor <= '0;
      qSign   <= 1'b0;
      rSign   <= 1'b0;
    end else begin
      state <= stateNext;
      done  <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            count <= '0;
            if (b == '0) begin
              // Zero divisor: quotient all ones, remainder is the raw dividend.
              remReg  <= a;
              quot    <= '1;
              divisor <= '0;
              qSign   <= 1'b0;
              rSign   <= 1'b0;
            end else begin
              remReg  <= '0;
              quot    <= aMag;
              divisor <= bMag;
              qSign   <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
              rSign   <= a[WIDTH-1] & signed_div;
            end
          end
        end
        BUSY: begin
          if (!cancel) begin
            remReg <= borrow ? shifted[WIDTH-1:0] : diff;
            quot   <= {quot[WIDTH-2:0], ~borrow};
            count  <= count + CNT_W'(1);
          end
        end
        FINISH: begin
          result <= {applySign(remReg, rSign), applySign(quot, qSign)};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a scoreboard of expected results is
// checked whenever done pulses; scenario tasks check timing and control.
module tb_div_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, start, signed_div, cancel;
  logic [W-1:0]   a, b;
  logic           stall, done;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] expQ[$];
  logic [2*W-1:0] lastExp;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .cancel(cancel), .a(a), .b(b), .stall(stall), .done(done), .result(result)
  );

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sgn);
    logic signed [W-1:0] sx, sy, q, r;
    if (y == '0) return {x, {W{1'b1}}};
    if (!sgn) return {x % y, x / y};
    if (x == {1'b1, {(W-1){1'b0}}} && y == {W{1'b1}}) return {{W{1'b0}}, x};
    sx = x;
    sy = y;
    q  = sx / sy;
    r  = sx % sy;
    return {r, q};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (done === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result %h with no request outstanding", result);
      end else begin
        e = expQ.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, e);
        end
      end
    end
  end

  task automatic doOp(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                      output int lat, output int stallCnt);
    @(posedge clk); #1;
    a = x; b = y; signed_div = sgn; start = 1'b1;
    lastExp = model(x, y, sgn);
    expQ.push_back(lastExp);
    #1;
    stallCnt = int'(stall);
    @(posedge clk); #1;
    start = 1'b0;
    stallCnt += int'(stall);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      stallCnt += int'(stall);
    end
  endtask

  task automatic countDone(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_divu;
    int lat, sc;
    doOp(32'd100, 32'd7, 1'b0, lat, sc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    checks++; if (sc !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", sc); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL divu_stall_at_done: got %b expected 0", stall); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL divu_result_hold: got %h expected %h", result, {32'd2, 32'd14});
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_signed;
    int lat, sc;
    doOp(32'hFFFF_FFF9, 32'd2, 1'b1, lat, sc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_neg_latency: got %0d expected 33", lat); end
    doOp(32'd7, 32'hFFFF_FFFE, 1'b1, lat, sc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_negb_latency: got %0d expected 33", lat); end
    doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, sc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_ovf_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_div_zero;
    int lat, sc;
    for (int s = 0; s < 2; s++) begin
      doOp(32'h1234, 32'd0, s[0], lat, sc);
      checks++; if (lat !== 1) begin errors++; $display("FAIL divzero_latency(s=%0d): got %0d expected 1", s, lat); end
      checks++; if (sc !== 1) begin errors++; $display("FAIL divzero_stall(s=%0d): got %0d expected 1", s, sc); end
    end
  endtask

  task automatic test_cancel;
    int n, lat, sc;
    logic [2*W-1:0] prev;
    prev = lastExp;
    @(posedge clk); #1;
    a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cancel_stall: got %b expected 0", stall); end
    checks++; if (result !== prev) begin errors++; $display("FAIL cancel_result: got %h expected %h", result, prev); end
    countDone(40, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL cancel_no_done: got %0d pulses expected 0", n); end
    doOp(32'd50, 32'd5, 1'b0, lat, sc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL after_cancel_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_reset_mid;
    int n;
    @(posedge clk); #1;
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", stall); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result: got %h expected 0", result); end
    countDone(40, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", n); end
  endtask

  task automatic test_start_cancel;
    int n;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd3; signed_div = 1'b0; start = 1'b1; cancel = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL startcancel_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL startcancel_accept: got stall %b expected 0", stall); end
    countDone(40, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL startcancel_no_done: got %0d pulses expected 0", n); end
  endtask

  task automatic test_random;
    int lat, sc, expLat;
    logic [W-1:0] x, y;
    logic sgn;
    for (int i = 0; i < 8; i++) begin
      x   = $urandom;
      y   = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 1000));
      sgn = $urandom_range(0, 1) == 1;
      doOp(x, y, sgn, lat, sc);
      expLat = (y == '0) ? 1 : 33;
      checks++;
      if (lat !== expLat) begin
        errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, expLat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_start_cancel();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d outstanding expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
